reg_file_wb: RTL

//  - Multicycle-datapath register file: write-back end feeding the A/B operand latches.
//  - Accepts write-back from the ALUOut/MDR stage via a valid/ready handshake.
//  - Serves two read ports with 1-cycle registered latency; outputs go straight to the A/B latches.
//  - After reset, a sequential scrub FSM clears every register before the file accepts traffic.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/reg_file_wb_if.sv | 26 ++
 rtl/reg_file_scrub.sv | 52 +++++
 rtl/reg_file_wb.sv | 90 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the write-back register file and its scrub controller.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;

    // Register r0 is hard-wired to zero on both read ports
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_wb_if.sv
// Read-port and write-back handshake bundle between the datapath and the register file.
interface reg_file_wb_if #(
    parameter int DATA_W = regfile_pkg::REGFILE_DATA_W,
    parameter int ADDR_W = regfile_pkg::REGFILE_ADDR_W
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              busy;

    modport master (
        output rs_addr, rt_addr, rd_en, wb_valid, wb_addr, wb_data,
        input  rs_data, rt_data, wb_ready, busy
    );

    modport slave (
        input  rs_addr, rt_addr, rd_en, wb_valid, wb_addr, wb_data,
        output rs_data, rt_data, wb_ready, busy
    );
endinterface

// File: rtl/reg_file_scrub.sv
// Post-reset scrub sequencer: walks every register address once, then parks in READY.
module reg_file_scrub
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              scrub_we,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        scrub_we = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_SCRUB: begin
                scrub_we = 1'b1;
                busy     = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign scrub_addr = ptr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCRUB;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back register file with registered dual read ports and post-reset scrub.
// Define REGFILE_WB_BYPASS_EN to forward a same-edge write-back to matching read ports.
module reg_file_wb
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_wb_if.slave  bus
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              scrub_we;
    logic [ADDR_W-1:0] scrub_addr;
    logic              scrub_busy;

    logic              wb_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;

    reg_file_scrub #(
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .clk        (clk),
        .reset      (reset),
        .scrub_we   (scrub_we),
        .scrub_addr (scrub_addr),
        .busy       (scrub_busy)
    );

    assign bus.busy     = scrub_busy;
    assign bus.wb_ready = ~scrub_busy;
    assign bus.rs_data  = rs_data_q;
    assign bus.rt_data  = rt_data_q;

    // Scrub and write-back never overlap: wb_ready is low for the whole scrub.
    always_comb begin
        wb_fire   = bus.wb_valid && bus.wb_ready;
        mem_we    = scrub_we || (wb_fire && (bus.wb_addr != ZERO_ADDR));
        mem_waddr = scrub_we ? scrub_addr : bus.wb_addr;
        mem_wdata = scrub_we ? '0 : bus.wb_data;
    end

    always_comb begin
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        if (bus.rd_en) begin
            rs_data_d = (scrub_busy || bus.rs_addr == ZERO_ADDR) ? '0 : mem_q[bus.rs_addr];
            rt_data_d = (scrub_busy || bus.rt_addr == ZERO_ADDR) ? '0 : mem_q[bus.rt_addr];
            if (BYPASS && wb_fire && bus.wb_addr != ZERO_ADDR) begin
                if (bus.wb_addr == bus.rs_addr) rs_data_d = bus.wb_data;
                if (bus.wb_addr == bus.rt_addr) rt_data_d = bus.wb_data;
            end
        end
    end

    // NOTE: the array has no reset term so it maps onto plain RAM; the scrub FSM clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else begin
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
        end
    end

endmodule
